spi_byte_master: RTL and testbench

//  SPI mode-0 byte engine: full-duplex shift of one byte per start pulse, MSB first.

---
 rtl/spi_byte_master.sv | 103 ++++++++++
 tb/tb_spi_byte_master.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/spi_byte_master.sv
// SPI mode-0 byte engine: one full-duplex byte per accepted start, MSB first.
// Feeds the boot sequencer's spi_* handshake; chip select is owned upstream.
//
// state   | meaning
// IDLE    | sclk low, waiting for start_i; mosi_o holds the last driven bit
// SCLK_LO | SCLK low half-period; MISO sampled on the edge that raises SCLK
// SCLK_HI | SCLK high half-period; MOSI advances on the edge that lowers SCLK
module spi_byte_master #(
  parameter int CLK_DIV = 2
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       start_i,
  input  logic [7:0] data_i,
  output logic [7:0] data_o,
  output logic       done_o,
  output logic       busy_o,
  output logic       sclk_o,
  output logic       mosi_o,
  input  logic       miso_i
);

  localparam int DIV_W = $clog2(CLK_DIV + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE,
    SCLK_LO,
    SCLK_HI
  } state_t;

  state_t           state;
  logic [7:0]       tx_sr;
  logic [7:0]       rx_sr;
  logic [2:0]       bit_cnt;
  logic [DIV_W-1:0] div_cnt;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state   <= IDLE;
      tx_sr   <= 8'h00;
      rx_sr   <= 8'h00;
      bit_cnt <= 3'd0;
      div_cnt <= '0;
      data_o  <= 8'h00;
      done_o  <= 1'b0;
      busy_o  <= 1'b0;
      sclk_o  <= 1'b0;
      mosi_o  <= 1'b0;
    end else begin
      done_o <= 1'b0;
      case (state)
        IDLE: begin
          sclk_o <= 1'b0;
          busy_o <= 1'b0;
          if (start_i) begin
            tx_sr   <= data_i;
            mosi_o  <= data_i[7];
            bit_cnt <= 3'd0;
            div_cnt <= '0;
            busy_o  <= 1'b1;
            state   <= SCLK_LO;
          end
        end

        SCLK_LO: begin
          if (div_cnt == DIV_LAST) begin
            sclk_o  <= 1'b1;
            rx_sr   <= {rx_sr[6:0], miso_i};
            div_cnt <= '0;
            state   <= SCLK_HI;
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end

        SCLK_HI: begin
          if (div_cnt == DIV_LAST) begin
            sclk_o  <= 1'b0;
            div_cnt <= '0;
            if (bit_cnt == 3'd7) begin
              // rx_sr already holds all 8 bits from the last rising edge
              data_o <= rx_sr;
              done_o <= 1'b1;
              busy_o <= 1'b0;
              state  <= IDLE;
            end else begin
              tx_sr   <= {tx_sr[6:0], 1'b0};
              mosi_o  <= tx_sr[6];
              bit_cnt <= bit_cnt + 3'd1;
              state   <= SCLK_LO;
            end
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_byte_master.sv
// Directed bench for spi_byte_master: CLK_DIV=2 and CLK_DIV=1 instances,
// scoreboard of expected received bytes popped on each done pulse.
module tb_spi_byte_master;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset = 1'b1, start = 1'b0, miso;
  logic [7:0] data_in = 8'h00, data_out;
  logic       done, busy, sclk, mosi;

  logic       reset1 = 1'b1, start1 = 1'b0, miso1;
  logic [7:0] data_in1 = 8'h00, data_out1;
  logic       done1, busy1, sclk1, mosi1;

  spi_byte_master #(.CLK_DIV(2)) u_dut (
    .clk_i(clk), .reset_i(reset), .start_i(start), .data_i(data_in),
    .data_o(data_out), .done_o(done), .busy_o(busy), .sclk_o(sclk),
    .mosi_o(mosi), .miso_i(miso)
  );

  spi_byte_master #(.CLK_DIV(1)) u_dut1 (
    .clk_i(clk), .reset_i(reset1), .start_i(start1), .data_i(data_in1),
    .data_o(data_out1), .done_o(done1), .busy_o(busy1), .sclk_o(sclk1),
    .mosi_o(mosi1), .miso_i(miso1)
  );

  // mode-0 slave: shifts out on SCLK fall, captures MOSI on SCLK rise
  logic       loop_mode = 1'b1;
  logic       slave_load = 1'b0;
  logic [7:0] slave_pat = 8'h00, slave_tx = 8'h00, slave_rx = 8'h00;
  assign miso  = loop_mode ? mosi : slave_tx[7];
  assign miso1 = mosi1;
  always @(posedge sclk) slave_rx <= {slave_rx[6:0], mosi};
  always @(negedge sclk or posedge slave_load)
    if (slave_load) slave_tx <= slave_pat;
    else            slave_tx <= {slave_tx[6:0], 1'b0};

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0, fails = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [7:0] exp_q[$];
  logic [7:0] exp_q1[$];
  int done_cnt = 0, viol = 0;
  logic prev_mosi = 1'b0;

  always @(negedge clk) begin
    if (sclk === 1'b1 && mosi !== prev_mosi) viol++;
    prev_mosi = mosi;
    if (done === 1'b1) begin
      done_cnt++;
      tests++;
      assert (exp_q.size() != 0) else begin
        fails++;
        $error("FAIL sb_extra_done: observed done with data %0h, expected no done", data_out);
      end
      if (exp_q.size() != 0) check("sb_data", data_out, exp_q.pop_front());
    end
    if (done1 === 1'b1) begin
      tests++;
      assert (exp_q1.size() != 0) else begin
        fails++;
        $error("FAIL sb1_extra_done: observed done with data %0h, expected no done", data_out1);
      end
      if (exp_q1.size() != 0) check("sb1_data", data_out1, exp_q1.pop_front());
    end
  end

  // inputs are driven and counters read 1 time unit after the falling edge
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic [7:0] d, output int t0);
    start   = 1'b1;
    data_in = d;
    t0      = cyc;
    step();
    start   = 1'b0;
    data_in = 8'($urandom);
  endtask

  task automatic wait_done(input int maxc, output int at);
    at = -1;
    for (int i = 0; i < maxc; i++) begin
      step();
      if (done === 1'b1) begin
        at = cyc;
        break;
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, at, at2, rises, bad, ones, dc, notog;
    logic ps;

    // reset state
    repeat (3) step();
    check("rst_data", data_out, 8'h00);
    check("rst_done", done, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_sclk", sclk, 1'b0);
    check("rst_mosi", mosi, 1'b0);
    reset  = 1'b0;
    reset1 = 1'b0;
    step();

    // 1: loopback A5, exact latency, busy window, 8 rising edges
    start = 1'b1; data_in = 8'hA5; t0 = cyc; exp_q.push_back(8'hA5);
    rises = 0; bad = 0; ps = sclk;
    for (int i = 1; i <= 33; i++) begin
      step();
      if (i == 1) begin start = 1'b0; data_in = 8'h00; end
      if (sclk === 1'b1 && ps === 1'b0) rises++;
      ps = sclk;
      if (i <= 32 && (busy !== 1'b1 || done !== 1'b0)) bad++;
    end
    check("t1_done_at_T33", done, 1'b1);
    check("t1_busy_at_T33", busy, 1'b0);
    check("t1_busy_window", bad, 0);
    check("t1_sclk_rises", rises, 8);
    check("t1_sclk_idle", sclk, 1'b0);
    step();
    check("t1_done_one_cycle", done, 1'b0);

    // 2: slave returns 3C while master sends 03
    slave_pat = 8'h3C; slave_load = 1'b1; step(); slave_load = 1'b0;
    loop_mode = 1'b0;
    pulse_start(8'h03, t0); exp_q.push_back(8'h3C);
    wait_done(40, at);
    check("t2_done_cycle", at, t0 + 33);
    check("t2_slave_rx", slave_rx, 8'h03);
    check("t2_mosi_stable_hi", viol, 0);
    loop_mode = 1'b1;
    step();

    // 5: reset mid-byte, then a clean transfer
    dc = done_cnt;
    pulse_start(8'hA5, t0);
    while (cyc < t0 + 12) step();
    reset = 1'b1;
    step();
    check("t5_sclk", sclk, 1'b0);
    check("t5_busy", busy, 1'b0);
    check("t5_done", done, 1'b0);
    check("t5_data", data_out, 8'h00);
    reset = 1'b0;
    step();
    pulse_start(8'h96, t0); exp_q.push_back(8'h96);
    wait_done(40, at);
    check("t5_post_done_cycle", at, t0 + 33);
    check("t5_done_count", done_cnt, dc + 1);
    step();

    // 3: start during busy is ignored
    dc = done_cnt; ones = 0; at = -1;
    pulse_start(8'h00, t0); exp_q.push_back(8'h00);
    for (int i = 0; i < 39; i++) begin
      if (cyc == t0 + 10) begin start = 1'b1; data_in = 8'hFF; end
      step();
      start = 1'b0;
      if (mosi === 1'b1) ones++;
      if (done === 1'b1) at = cyc;
    end
    check("t3_done_count", done_cnt, dc + 1);
    check("t3_done_cycle", at, t0 + 33);
    check("t3_mosi_zero", ones, 0);

    // 4: restart in each done cycle, three bytes
    dc = done_cnt;
    pulse_start(8'h03, t0); exp_q.push_back(8'h03);
    wait_done(40, at);
    check("t4_first_done", at, t0 + 33);
    for (int k = 0; k < 2; k++) begin
      start = 1'b1; data_in = 8'h00; exp_q.push_back(8'h00);
      step();
      start = 1'b0;
      wait_done(40, at2);
      check("t4_spacing", at2, at + 33);
      at = at2;
    end
    check("t4_done_count", done_cnt, dc + 3);

    // 6: CLK_DIV=1 loopback 5A
    start1 = 1'b1; data_in1 = 8'h5A; t0 = cyc; exp_q1.push_back(8'h5A);
    notog = 0; bad = 0; ps = sclk1;
    for (int i = 1; i <= 17; i++) begin
      step();
      if (i == 1) begin start1 = 1'b0; data_in1 = 8'h00; end
      if (i >= 2 && sclk1 === ps) notog++;
      ps = sclk1;
      if (i < 17 && done1 !== 1'b0) bad++;
    end
    check("t6_done_at_T17", done1, 1'b1);
    check("t6_no_early_done", bad, 0);
    check("t6_sclk_toggles", notog, 0);
    step();
    check("t6_done_one_cycle", done1, 1'b0);

    check("sb_queue_empty", exp_q.size(), 0);
    check("sb1_queue_empty", exp_q1.size(), 0);
    check("mosi_stable_hi_all", viol, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
